axis_uart_packer: RTL and testbench

//  Packs latched X/Y/Z 16-bit accelerometer words into a byte-framed stream for the UART Tx.

---
 rtl/axis_uart_packer.sv | 156 +++++++++++++++
 tb/tb_axis_uart_packer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_packer.sv
// ============================================================================
// Module  : axis_uart_packer
// Brief   : Snapshots X/Y/Z accelerometer words and streams them as a byte frame
//           to a UART Tx.
//           Optional macro AXIS_PACKER_CHECKSUM_EN appends a checksum byte.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axis_uart_packer #(
    parameter logic [7:0]  HEADER_BYTE = 8'hA5,
    parameter int unsigned DECIMATE    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_trig,
    input  logic [15:0] x_data,
    input  logic [15:0] y_data,
    input  logic [15:0] z_data,
    input  logic        tx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun,
    input  logic        ovr_clr
);

`ifdef AXIS_PACKER_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd7;
`else
    localparam logic [2:0] LAST_IDX = 3'd6;
`endif
    localparam logic [7:0] DEC_LAST = 8'(DECIMATE - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  dec_cnt;
    logic [2:0]  byte_idx;
    logic [2:0]  next_idx;
    logic [7:0]  next_byte;
    logic [15:0] snap_x;
    logic [15:0] snap_y;
    logic [15:0] snap_z;
    logic        start;
    logic        last_xfer;
    logic        xfer;

    assign xfer     = tx_valid & tx_ready;
    assign next_idx = byte_idx + 3'd1;
    assign busy     = (state == SEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        last_xfer = 1'b0;
        case (state)
            IDLE: begin
                if (sample_trig && (dec_cnt == DEC_LAST)) begin
                    start     = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (xfer && (byte_idx == LAST_IDX)) begin
                    last_xfer = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef AXIS_PACKER_CHECKSUM_EN
    logic [7:0] csum;
    assign csum = snap_x[15:8] + snap_x[7:0] + snap_y[15:8] + snap_y[7:0]
                + snap_z[15:8] + snap_z[7:0];
`endif

    // Byte presented after the current one transfers; index 0 is the header.
    always_comb begin
        next_byte = 8'h00;
        case (next_idx)
            3'd1:    next_byte = snap_x[15:8];
            3'd2:    next_byte = snap_x[7:0];
            3'd3:    next_byte = snap_y[15:8];
            3'd4:    next_byte = snap_y[7:0];
            3'd5:    next_byte = snap_z[15:8];
            3'd6:    next_byte = snap_z[7:0];
`ifdef AXIS_PACKER_CHECKSUM_EN
            3'd7:    next_byte = csum;
`endif
            default: next_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt    <= 8'd0;
            byte_idx   <= 3'd0;
            snap_x     <= 16'd0;
            snap_y     <= 16'd0;
            snap_z     <= 16'd0;
            tx_byte    <= 8'd0;
            tx_valid   <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if ((state == IDLE) && sample_trig) begin
                dec_cnt <= start ? 8'd0 : dec_cnt + 8'd1;
            end

            if (start) begin
                snap_x   <= x_data;
                snap_y   <= y_data;
                snap_z   <= z_data;
                byte_idx <= 3'd0;
                tx_byte  <= HEADER_BYTE;
                tx_valid <= 1'b1;
            end else if (last_xfer) begin
                byte_idx   <= 3'd0;
                tx_byte    <= 8'd0;
                tx_valid   <= 1'b0;
                frame_done <= 1'b1;
            end else if ((state == SEND) && xfer) begin
                byte_idx <= next_idx;
                tx_byte  <= next_byte;
            end

            // A new overrun in the same cycle as a clear takes priority.
            if ((state == SEND) && sample_trig) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_uart_packer.sv
// ============================================================================
// Module  : tb_axis_uart_packer
// Brief   : Self-checking bench for axis_uart_packer (DECIMATE=1 and DECIMATE=3).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axis_uart_packer;

    localparam logic [7:0] HDR = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        trig = 1'b0;
    logic        trig3 = 1'b0;
    logic        tx_ready = 1'b0;
    logic        tx_ready3 = 1'b0;
    logic        ovr_clr = 1'b0;
    logic        ovr_clr3 = 1'b0;
    logic [15:0] x_data = 16'd0;
    logic [15:0] y_data = 16'd0;
    logic [15:0] z_data = 16'd0;

    logic [7:0]  tx_byte,  tx_byte3;
    logic        tx_valid, tx_valid3;
    logic        busy,     busy3;
    logic        frame_done, frame_done3;
    logic        overrun,  overrun3;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    axis_uart_packer #(.HEADER_BYTE(HDR), .DECIMATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .sample_trig(trig),
        .x_data(x_data), .y_data(y_data), .z_data(z_data),
        .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_valid(tx_valid),
        .busy(busy), .frame_done(frame_done), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    axis_uart_packer #(.HEADER_BYTE(HDR), .DECIMATE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .sample_trig(trig3),
        .x_data(x_data), .y_data(y_data), .z_data(z_data),
        .tx_ready(tx_ready3), .tx_byte(tx_byte3), .tx_valid(tx_valid3),
        .busy(busy3), .frame_done(frame_done3), .overrun(overrun3), .ovr_clr(ovr_clr3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference frame: header, big-endian axis words, optional mod-256 byte sum.
    function automatic void build_frame(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
        int w[3];
        w[0] = int'(x);
        w[1] = int'(y);
        w[2] = int'(z);
        exp_q = {};
        exp_q.push_back(HDR);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'(w[i] / 256));
            exp_q.push_back(8'(w[i] % 256));
        end
`ifdef AXIS_PACKER_CHECKSUM_EN
        begin
            int sum;
            sum = 0;
            for (int i = 0; i < 3; i++) sum += (w[i] / 256) + (w[i] % 256);
            exp_q.push_back(8'(sum % 256));
        end
`endif
    endfunction

    // mode: 0 ready always, 1 ready 1-of-3, 2 random ready.
    // inj : 0 none, 1 trig mid-frame and at last transfer, 2 trig+ovr_clr mid-frame,
    //       3 trig only at last transfer.
    task automatic run_frame(input logic [15:0] x, input logic [15:0] y,
                             input logic [15:0] z, input int mode, input int inj);
        int idx;
        int cyc;
        logic stalled;
        logic rdy;
        logic [7:0] prev;
        build_frame(x, y, z);
        x_data = x;
        y_data = y;
        z_data = z;
        trig = 1'b1;
        step();
        trig = 1'b0;
        chk("start_valid", {15'd0, tx_valid}, 16'd1);
        chk("start_busy", {15'd0, busy}, 16'd1);
        chk("start_byte", {8'd0, tx_byte}, {8'd0, HDR});
        idx = 0;
        cyc = 0;
        stalled = 1'b0;
        prev = 8'd0;
        while (idx < exp_q.size() && cyc < 200) begin
            if (stalled) chk("stall_byte", {8'd0, tx_byte}, {8'd0, prev});
            chk("valid_hold", {15'd0, tx_valid}, 16'd1);
            chk("busy_hold", {15'd0, busy}, 16'd1);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 2);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tx_ready = rdy;
            x_data = 16'($urandom);
            y_data = 16'($urandom);
            z_data = 16'($urandom);
            trig = ((inj == 1 || inj == 2) && cyc == 2) ||
                   ((inj == 1 || inj == 3) && rdy && idx == exp_q.size() - 1);
            ovr_clr = (inj == 2 && cyc == 2);
            if (rdy) begin
                chk("frame_byte", {8'd0, tx_byte}, {8'd0, exp_q[idx]});
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                prev = tx_byte;
            end
            step();
            cyc++;
        end
        trig = 1'b0;
        ovr_clr = 1'b0;
        tx_ready = 1'b0;
        chk("frame_len", 16'(idx), 16'(exp_q.size()));
        chk("end_valid", {15'd0, tx_valid}, 16'd0);
        chk("end_busy", {15'd0, busy}, 16'd0);
        chk("end_done", {15'd0, frame_done}, 16'd1);
        step();
        chk("done_pulse", {15'd0, frame_done}, 16'd0);
        chk("no_restart", {15'd0, tx_valid}, 16'd0);
    endtask

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_byte", {8'd0, tx_byte}, 16'd0);
        chk("rst_valid", {15'd0, tx_valid}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, frame_done}, 16'd0);
        chk("rst_ovr", {15'd0, overrun}, 16'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_valid", {15'd0, tx_valid}, 16'd0);

        // Basic back-to-back frame, then backpressure
        run_frame(16'h1234, 16'hABCD, 16'h8001, 0, 0);
        chk("basic_ovr", {15'd0, overrun}, 16'd0);
        run_frame(16'h1234, 16'hABCD, 16'h8001, 1, 0);
        for (int i = 0; i < 4; i++) begin
            run_frame(16'($urandom), 16'($urandom), 16'($urandom), 2, 0);
            step();
        end
        chk("rand_ovr", {15'd0, overrun}, 16'd0);

        // Overrun: trig during frame and at last transfer
        run_frame(16'($urandom), 16'($urandom), 16'($urandom), 0, 1);
        chk("ovr_set", {15'd0, overrun}, 16'd1);
        run_frame(16'($urandom), 16'($urandom), 16'($urandom), 1, 2);
        chk("ovr_set_wins", {15'd0, overrun}, 16'd1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("ovr_clear", {15'd0, overrun}, 16'd0);
        run_frame(16'($urandom), 16'($urandom), 16'($urandom), 0, 3);
        chk("ovr_last_xfer", {15'd0, overrun}, 16'd1);
        step();
        run_frame(16'($urandom), 16'($urandom), 16'($urandom), 2, 0);

        // Asynchronous reset mid-frame
        x_data = 16'($urandom);
        trig = 1'b1;
        step();
        trig = 1'b0;
        tx_ready = 1'b1;
        step();
        chk("mid_busy", {15'd0, busy}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_byte", {8'd0, tx_byte}, 16'd0);
        chk("arst_valid", {15'd0, tx_valid}, 16'd0);
        chk("arst_busy", {15'd0, busy}, 16'd0);
        chk("arst_ovr", {15'd0, overrun}, 16'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        tx_ready = 1'b0;
        chk("post_rst_valid", {15'd0, tx_valid}, 16'd0);
        chk("post_rst_busy", {15'd0, busy}, 16'd0);
        run_frame(16'($urandom), 16'($urandom), 16'($urandom), 0, 0);

        // Decimation by 3: frames on the 3rd and 6th trigger only
        for (int k = 0; k < 6; k++) begin
            x_data = 16'($urandom);
            y_data = 16'($urandom);
            z_data = 16'($urandom);
            build_frame(x_data, y_data, z_data);
            trig3 = 1'b1;
            step();
            trig3 = 1'b0;
            if (k % 3 == 2) begin
                tx_ready3 = 1'b1;
                for (int j = 0; j < exp_q.size(); j++) begin
                    chk("dec_valid", {15'd0, tx_valid3}, 16'd1);
                    chk("dec_byte", {8'd0, tx_byte3}, {8'd0, exp_q[j]});
                    x_data = 16'($urandom);
                    step();
                end
                chk("dec_done", {15'd0, frame_done3}, 16'd1);
                tx_ready3 = 1'b0;
            end else begin
                chk("dec_skip", {15'd0, tx_valid3}, 16'd0);
            end
            repeat (10) step();
            chk("dec_idle", {15'd0, busy3}, 16'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
